// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver: glyph table,
// special segment patterns and a constant-width helper.
package seg_pkg;

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low a..g in bits 6:0, dp off in bit 7; index 0 is the rightmost entry.
    localparam logic [15:0][7:0] SEG_GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock, WIDTH clocks total.
// bcd/ovf present the final result combinationally during the done cycle.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    logic [WIDTH-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_nxt;
    logic             shift_out;
    logic             ovf_q;
    logic             ovf_nxt;
    logic [CNT_W-1:0] iter_q;

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {shift_out, bcd_nxt} = {bcd_adj, bin_q[WIDTH-1]};
        ovf_nxt = ovf_q | shift_out;
    end

    assign done = busy && (iter_q == CNT_W'(WIDTH - 1));
    assign bcd  = bcd_nxt;
    assign ovf  = ovf_nxt;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy   <= 1'b0;
            bin_q  <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            iter_q <= '0;
        end else if (busy) begin
            bcd_q  <= bcd_nxt;
            bin_q  <= bin_q << 1;
            ovf_q  <= ovf_nxt;
            iter_q <= iter_q + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            iter_q <= '0;
            busy   <= 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: hex/decimal display register, digit scan with
// PWM brightness and an anti-ghost blank slot, registered glitch-free outputs.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 16,
    parameter int SCAN_DIV    = 1024,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [WIDTH-1:0]       value,
    input  logic                   value_valid,
    input  logic                   mode_dec,
    input  logic                   blank_lz,
    input  logic [DIGITS-1:0]      dots,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic                   busy,
    output logic [7:0]             seg_n,
    output logic [DIGITS-1:0]      dig_en
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int PRE_W = clog2(SCAN_DIV);
    localparam int IDX_W = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);

    logic             accept;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_ovf;
    logic [BCD_W-1:0] hex_disp;
    logic             hex_ovf;

    logic [BCD_W-1:0] disp_q;
    logic             ovf_q;
    logic [PRE_W-1:0] pre_q;
    logic [IDX_W-1:0] idx_q;

    assign accept = value_valid && !busy;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .CLK   (CLK),
        .RST_N (RST_N),
        .start (accept && mode_dec),
        .bin   (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    generate
        if (WIDTH > BCD_W) begin : g_hex_wide
            assign hex_disp = value[BCD_W-1:0];
            assign hex_ovf  = |value[WIDTH-1:BCD_W];
        end else begin : g_hex_narrow
            assign hex_disp = BCD_W'(value);
            assign hex_ovf  = 1'b0;
        end
    endgenerate

    // Display and overflow only ever change together, so no partial result is shown.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (conv_done) begin
            disp_q <= conv_bcd;
            ovf_q  <= conv_ovf;
        end else if (accept && !mode_dec) begin
            disp_q <= hex_disp;
            ovf_q  <= hex_ovf;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    logic [BRIGHT_BITS-1:0] phase;
    logic                   lit;
    logic [DIGITS-1:0]      lz_blank;
    logic                   zero_run;
    logic [6:0]             body;
    logic [7:0]             seg_nxt;
    logic [DIGITS-1:0]      dig_nxt;

    assign phase = pre_q[PRE_W-1 -: BRIGHT_BITS];
    assign lit   = (phase < brightness) && (pre_q != '0);

    // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_q[4*i +: 4] == 4'd0);
            if (i > 0) begin
                lz_blank[i] = blank_lz && zero_run;
            end
        end
    end

    always_comb begin
        seg_nxt = SEG_BLANK;
        dig_nxt = '0;
        body    = SEG_BLANK[6:0];
        if (lit) begin
            if (ovf_q) begin
                body = SEG_DASH[6:0];
            end else if (!lz_blank[idx_q]) begin
                body = SEG_GLYPH[disp_q[4*idx_q +: 4]][6:0];
            end
            seg_nxt = {~dots[idx_q], body};
            dig_nxt = DIGITS'(1) << idx_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_n  <= SEG_BLANK;
            dig_en <= '0;
        end else begin
            seg_n  <= seg_nxt;
            dig_en <= dig_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: arithmetic reference model as a
// per-cycle scoreboard plus directed scenario tasks and a 6-digit instance.
module tb_seg_scan_display;

    localparam int DIGITS      = 4;
    localparam int WIDTH       = 16;
    localparam int SCAN_DIV    = 1024;
    localparam int BRIGHT_BITS = 4;
    localparam int BUDGET      = 2 * DIGITS * SCAN_DIV;

    localparam int D6 = 6;
    localparam int W6 = 20;
    localparam int S6 = 16;

    logic                   CLK = 1'b0;
    logic                   RST_N = 1'b0;
    logic [WIDTH-1:0]       value;
    logic                   value_valid;
    logic                   mode_dec;
    logic                   blank_lz;
    logic [DIGITS-1:0]      dots;
    logic [BRIGHT_BITS-1:0] brightness;
    logic                   busy;
    logic [7:0]             seg_n;
    logic [DIGITS-1:0]      dig_en;

    logic [W6-1:0]          value6;
    logic                   valid6;
    logic                   mode6;
    logic [D6-1:0]          dots6;
    logic                   busy6;
    logic [7:0]             seg6;
    logic [D6-1:0]          dig6;

    int vectors     = 0;
    int miscompares = 0;
    bit sb_on       = 1'b0;

    byte unsigned glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 CLK = ~CLK;

    seg_scan_display #(
        .DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .BRIGHT_BITS(BRIGHT_BITS)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .value(value), .value_valid(value_valid),
        .mode_dec(mode_dec), .blank_lz(blank_lz), .dots(dots), .brightness(brightness),
        .busy(busy), .seg_n(seg_n), .dig_en(dig_en)
    );

    seg_scan_display #(
        .DIGITS(D6), .WIDTH(W6), .SCAN_DIV(S6), .BRIGHT_BITS(BRIGHT_BITS)
    ) dut6 (
        .CLK(CLK), .RST_N(RST_N), .value(value6), .value_valid(valid6),
        .mode_dec(mode6), .blank_lz(1'b0), .dots(dots6), .brightness(brightness),
        .busy(busy6), .seg_n(seg6), .dig_en(dig6)
    );

    // Reference model: the display is held as a number plus radix; digits are
    // extracted by division and the scan position follows from the cycle count.
    longint       mdl_num;
    int           mdl_radix;
    bit           mdl_ovf;
    int           mdl_busy_left;
    longint       mdl_pend_num;
    bit           mdl_pend_ovf;
    longint       mdl_cyc;
    logic [7:0]   exp_seg;
    logic [DIGITS-1:0] exp_dig;
    logic         exp_busy;

    always @(posedge CLK or negedge RST_N) begin : model
        int           p;
        int           idx;
        longint       scale;
        longint       digit;
        byte unsigned bodyv;
        if (!RST_N) begin
            mdl_num       = 0;
            mdl_radix     = 16;
            mdl_ovf       = 1'b0;
            mdl_busy_left = 0;
            mdl_cyc       = 0;
            exp_seg       = 8'hFF;
            exp_dig       = '0;
            exp_busy      = 1'b0;
        end else begin
            p   = int'(mdl_cyc % SCAN_DIV);
            idx = int'((mdl_cyc / SCAN_DIV) % DIGITS);
            if (p != 0 && (p / (SCAN_DIV >> BRIGHT_BITS)) < int'(brightness)) begin
                scale = 1;
                for (int k = 0; k < idx; k++) scale = scale * mdl_radix;
                digit = (mdl_num / scale) % mdl_radix;
                if (mdl_ovf) bodyv = 8'hBF;
                else if (blank_lz && idx > 0 && (mdl_num / scale) == 0) bodyv = 8'hFF;
                else bodyv = glyph[int'(digit)];
                exp_seg = {~dots[idx], bodyv[6:0]};
                exp_dig = DIGITS'(1) << idx;
            end else begin
                exp_seg = 8'hFF;
                exp_dig = '0;
            end
            if (mdl_busy_left > 0) begin
                mdl_busy_left--;
                if (mdl_busy_left == 0) begin
                    mdl_num   = mdl_pend_num;
                    mdl_radix = 10;
                    mdl_ovf   = mdl_pend_ovf;
                end
            end else if (value_valid) begin
                if (mode_dec) begin
                    mdl_busy_left = WIDTH;
                    mdl_pend_ovf  = longint'(value) >= 10 ** DIGITS;
                    mdl_pend_num  = longint'(value) % (10 ** DIGITS);
                end else begin
                    mdl_radix = 16;
                    mdl_ovf   = longint'(value) >= 16 ** DIGITS;
                    mdl_num   = longint'(value) % (16 ** DIGITS);
                end
            end
            exp_busy = mdl_busy_left > 0;
            mdl_cyc++;
        end
    end

    always @(posedge CLK) begin
        #1;
        if (sb_on) begin
            vectors++;
            if (seg_n !== exp_seg) begin
                miscompares++;
                $display("FAIL sb_seg_n t=%0t: got %h expected %h", $time, seg_n, exp_seg);
            end
            vectors++;
            if (dig_en !== exp_dig) begin
                miscompares++;
                $display("FAIL sb_dig_en t=%0t: got %b expected %b", $time, dig_en, exp_dig);
            end
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL sb_busy t=%0t: got %b expected %b", $time, busy, exp_busy);
            end
        end
    end

    // Stimulus utilities (no comparisons inside).
    task automatic load(input logic [WIDTH-1:0] v, input logic dec);
        @(negedge CLK);
        value       = v;
        mode_dec    = dec;
        value_valid = 1'b1;
        @(negedge CLK);
        value_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(posedge CLK); #1;
            n++;
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic wait_dig(input logic [DIGITS-1:0] target, output logic [7:0] seg,
                            output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        seg    = 8'hxx;
        while (!ok && cycles < BUDGET) begin
            @(posedge CLK); #1;
            cycles++;
            if (dig_en === target) begin
                ok  = 1'b1;
                seg = seg_n;
            end
        end
    endtask

    task automatic wait_dig6(input logic [D6-1:0] target, output logic [7:0] seg, output bit ok);
        int n;
        ok  = 1'b0;
        n   = 0;
        seg = 8'hxx;
        while (!ok && n < 4 * D6 * S6) begin
            @(posedge CLK); #1;
            n++;
            if (dig6 === target) begin
                ok  = 1'b1;
                seg = seg6;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] s;
        int         c;
        bit         ok;
        #1;
        vectors++;
        if (seg_n !== 8'hFF || dig_en !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got seg=%h dig=%b busy=%b expected FF/0/0", seg_n, dig_en, busy);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (300) @(posedge CLK);
        load(16'd1234, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if (busy !== 1'b1 || dig_en === '0) begin
            miscompares++;
            $display("FAIL reset_precond: got busy=%b dig=%b expected busy=1 and a lit digit", busy, dig_en);
        end
        #2 RST_N = 1'b0;
        #1;
        vectors++;
        if (seg_n !== 8'hFF || dig_en !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got seg=%h dig=%b busy=%b expected FF/0/0", seg_n, dig_en, busy);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_dig(DIGITS'(1), s, c, ok);
        vectors++;
        if (!ok || s !== 8'hC0) begin
            miscompares++;
            $display("FAIL reset_display_zero: got seg=%h ok=%0d expected C0", s, ok);
        end
    endtask

    task automatic test_hex();
        logic [15:0] v;
        logic [7:0]  s;
        int          c;
        bit          ok;
        v = 16'hBEEF;
        load(v, 1'b0);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hex_busy: got %b expected 0", busy);
        end
        for (int k = 0; k < DIGITS; k++) begin
            wait_dig(DIGITS'(1) << k, s, c, ok);
            vectors++;
            if (!ok || s !== glyph[(v >> (4 * k)) & 16'hF]) begin
                miscompares++;
                $display("FAIL hex_digit%0d: got %h expected %h", k, s, glyph[(v >> (4 * k)) & 16'hF]);
            end
            if (k >= 2) begin
                vectors++;
                if (c !== SCAN_DIV) begin
                    miscompares++;
                    $display("FAIL hex_slot_period%0d: got %0d expected %0d", k, c, SCAN_DIV);
                end
            end
        end
    endtask

    task automatic test_decimal();
        logic [7:0] s;
        int         c;
        int         n;
        bit         ok;
        @(negedge CLK);
        value       = 16'd1234;
        mode_dec    = 1'b1;
        value_valid = 1'b1;
        @(negedge CLK);
        value = 16'd9999;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(posedge CLK); #1;
            if (busy === 1'b1) n++;
            else ok = 1'b1;
        end
        @(negedge CLK);
        value_valid = 1'b0;
        vectors++;
        if (n !== WIDTH - 1) begin
            miscompares++;
            $display("FAIL dec_busy_len: got %0d expected %0d", n + 1, WIDTH);
        end
        for (int k = 0; k < DIGITS; k++) begin
            wait_dig(DIGITS'(1) << k, s, c, ok);
            vectors++;
            if (!ok || s !== glyph[(1234 / (10 ** k)) % 10]) begin
                miscompares++;
                $display("FAIL dec_digit%0d: got %h expected %h", k, s, glyph[(1234 / (10 ** k)) % 10]);
            end
        end
    endtask

    task automatic test_overflow_blank();
        logic [7:0] s;
        logic [7:0] want [DIGITS];
        int         c;
        bit         ok;
        load(16'd12345, 1'b1);
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ovf_idle: got busy=%b expected 0 within budget", busy);
        end
        for (int k = 0; k < DIGITS; k++) begin
            wait_dig(DIGITS'(1) << k, s, c, ok);
            vectors++;
            if (!ok || s !== 8'hBF) begin
                miscompares++;
                $display("FAIL ovf_digit%0d: got %h expected BF", k, s);
            end
        end
        @(negedge CLK);
        blank_lz = 1'b1;
        dots     = 4'b0010;
        load(16'd7, 1'b1);
        wait_idle(ok);
        want = '{8'hF8, 8'h7F, 8'hFF, 8'hFF};
        for (int k = 0; k < DIGITS; k++) begin
            wait_dig(DIGITS'(1) << k, s, c, ok);
            vectors++;
            if (!ok || s !== want[k]) begin
                miscompares++;
                $display("FAIL blank_digit%0d: got %h expected %h", k, s, want[k]);
            end
        end
        @(negedge CLK);
        blank_lz = 1'b0;
        dots     = '0;
    endtask

    task automatic test_brightness();
        int lit;
        @(negedge CLK);
        brightness = '0;
        repeat (2) @(posedge CLK);
        lit = 0;
        repeat (2 * SCAN_DIV) begin
            @(posedge CLK); #1;
            if (dig_en !== '0) lit++;
        end
        vectors++;
        if (lit !== 0) begin
            miscompares++;
            $display("FAIL bright0_lit: got %0d expected 0", lit);
        end
        @(negedge CLK);
        brightness = 4'd8;
        repeat (2) @(posedge CLK);
        lit = 0;
        repeat (DIGITS * SCAN_DIV) begin
            @(posedge CLK); #1;
            if (dig_en !== '0) lit++;
        end
        vectors++;
        if (lit !== DIGITS * 511) begin
            miscompares++;
            $display("FAIL bright8_lit: got %0d expected %0d", lit, DIGITS * 511);
        end
        @(negedge CLK);
        brightness = 4'd15;
    endtask

    task automatic test_back_to_back();
        int  lows;
        bit  b16;
        bit  b33;
        @(negedge CLK);
        value       = 16'($urandom);
        mode_dec    = 1'b1;
        value_valid = 1'b1;
        lows = 0;
        b16  = 1'b1;
        b33  = 1'b1;
        for (int s = 0; s < 34; s++) begin
            @(posedge CLK); #1;
            if (busy !== 1'b1) lows++;
            if (s == 16) b16 = busy;
            if (s == 33) b33 = busy;
            @(negedge CLK);
            value = 16'($urandom);
        end
        value_valid = 1'b0;
        vectors++;
        if (lows !== 2 || b16 !== 1'b0 || b33 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy: got lows=%0d busy16=%b busy33=%b expected 2/0/0", lows, b16, b33);
        end
        repeat (WIDTH + 2) @(posedge CLK);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            @(negedge CLK);
            dots       = DIGITS'($urandom);
            blank_lz   = 1'($urandom);
            brightness = BRIGHT_BITS'($urandom_range(1, 15));
            load(($urandom % 2) ? 16'($urandom) : 16'($urandom % 200), 1'($urandom));
            repeat (DIGITS * SCAN_DIV + 16) begin
                @(posedge CLK); #1;
                vectors++;
                if ($countones(dig_en) > 1) begin
                    miscompares++;
                    $display("FAIL rand_onehot: got %b expected at most one bit", dig_en);
                end
                @(negedge CLK);
                value_valid = ($urandom % 400) == 0;
                value       = 16'($urandom);
                mode_dec    = 1'($urandom);
            end
            value_valid = 1'b0;
        end
        @(negedge CLK);
        brightness = 4'd15;
        blank_lz   = 1'b0;
        dots       = '0;
    endtask

    task automatic test_param();
        logic [7:0] s;
        bit         ok;
        int         n;
        @(negedge CLK);
        value6 = 20'd999999;
        mode6  = 1'b1;
        valid6 = 1'b1;
        @(negedge CLK);
        valid6 = 1'b0;
        n = 0;
        while (busy6 === 1'b1 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        vectors++;
        if (n !== W6) begin
            miscompares++;
            $display("FAIL p6_busy_len: got %0d expected %0d", n, W6);
        end
        for (int k = 0; k < D6; k++) begin
            wait_dig6(D6'(1) << k, s, ok);
            vectors++;
            if (!ok || s !== 8'h90) begin
                miscompares++;
                $display("FAIL p6_dec_digit%0d: got %h expected 90", k, s);
            end
        end
        @(negedge CLK);
        value6 = 20'hFFFFF;
        mode6  = 1'b0;
        valid6 = 1'b1;
        @(negedge CLK);
        valid6 = 1'b0;
        for (int k = 0; k < D6; k++) begin
            wait_dig6(D6'(1) << k, s, ok);
            vectors++;
            if (!ok || s !== glyph[(k < 5) ? 15 : 0]) begin
                miscompares++;
                $display("FAIL p6_hex_digit%0d: got %h expected %h", k, s, glyph[(k < 5) ? 15 : 0]);
            end
        end
    endtask

    initial begin
        value       = '0;
        value_valid = 1'b0;
        mode_dec    = 1'b0;
        blank_lz    = 1'b0;
        dots        = '0;
        brightness  = 4'd15;
        value6      = '0;
        valid6      = 1'b0;
        mode6       = 1'b0;
        dots6       = '0;
        RST_N       = 1'b0;
        repeat (3) @(posedge CLK);
        sb_on = 1'b1;
        test_reset();
        test_hex();
        test_decimal();
        test_overflow_blank();
        test_brightness();
        test_back_to_back();
        test_random();
        test_param();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
